// File: rtl/sbox_arb_pkg.sv
// sbox_arb_pkg
// Shared types and defaults for the S-box ROM arbiter.
//   owner_e : which requester a lookup belongs to (SS = SubBytes, KS = key schedule)
//   state_e : arbiter FSM state
//   tag_t   : return-path tag {valid, owner} carried alongside each ROM read
package sbox_arb_pkg;

    typedef enum logic {
        OWN_SS = 1'b0,
        OWN_KS = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OWN_SS = 2'd1,
        S_OWN_KS = 2'd2
    } state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam int unsigned ROM_LAT_DEF   = 1;
    localparam int unsigned MAX_BURST_DEF = 4;

endpackage

// File: rtl/sbox_arb_tagpipe.sv
// sbox_arb_tagpipe
// Shift register of {valid, owner} tags that tracks ROM reads in flight so the
// returning data can be steered to the requester that issued the lookup.
//   clk_i       : clock
//   rst_ni      : async active-low clear (drops every in-flight tag)
//   push_i      : a lookup was granted this cycle
//   owner_i     : requester of the granted lookup
//   tag_o       : tag of the lookup whose data is on the ROM output this cycle
//   any_valid_o : at least one tag in flight
module sbox_arb_tagpipe
    import sbox_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  owner_e owner_i,
    output tag_t   tag_o,
    output logic   any_valid_o
);

    tag_t pipe_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: push_i, owner: owner_i};
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

    always_comb begin
        any_valid_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid_o = any_valid_o | pipe_q[i].valid;
        end
    end

endmodule

// File: rtl/sbox_arbiter.sv
// sbox_arbiter
// Shares one synchronous-read S-box ROM between SubBytes (SS) and the key
// schedule (KS). Round-robin between the two, optional locked bursts capped at
// MAX_BURST when the other side is waiting, in-order tagged data return.
//   clk_i, rst_ni                 : clock, async active-low reset
//   ss_req_i/ss_addr_i/ss_lock_i  : SS lookup request, byte, keep-ownership hint
//   ss_gnt_o                      : SS request accepted this cycle (combinational)
//   ss_rvalid_o/ss_rdata_o        : substituted byte returned to SS
//   ks_*                          : same set for KS
//   rom_ce_o/rom_re_o/rom_addr_o  : registered ROM controls
//   rom_data_i                    : ROM read data
//   busy_o                        : any lookup in flight
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | round-robin between SS and KS, last_owner loses a conflict
// S_OWN_SS | SS holds a locked burst; KS only on forced hand-over
// S_OWN_KS | KS holds a locked burst; SS only on forced hand-over
module sbox_arbiter
    import sbox_arb_pkg::*;
#(
    parameter int unsigned ROM_LAT   = ROM_LAT_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ss_req_i,
    input  logic [7:0] ss_addr_i,
    input  logic       ss_lock_i,
    output logic       ss_gnt_o,
    output logic       ss_rvalid_o,
    output logic [7:0] ss_rdata_o,
    input  logic       ks_req_i,
    input  logic [7:0] ks_addr_i,
    input  logic       ks_lock_i,
    output logic       ks_gnt_o,
    output logic       ks_rvalid_o,
    output logic [7:0] ks_rdata_o,
    output logic       rom_ce_o,
    output logic       rom_re_o,
    output logic [7:0] rom_addr_o,
    input  logic [7:0] rom_data_i,
    output logic       busy_o
);

    localparam int unsigned CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] BURST_ONE = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] burst_q, burst_d;
    owner_e        last_q, last_d;
    logic          gnt_ss, gnt_ks;
    logic          do_arb;
    logic          grant_any;

    logic          rom_ce_q;
    logic          rom_re_q;
    logic [7:0]    rom_addr_q;

    tag_t          tag_out;
    logic          tag_busy;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        last_d  = last_q;
        gnt_ss  = 1'b0;
        gnt_ks  = 1'b0;
        do_arb  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                do_arb = 1'b1;
            end
            S_OWN_SS: begin
                if (!ss_req_i) begin
                    // Owner walked away: fall back to normal arbitration now.
                    state_d = S_IDLE;
                    burst_d = '0;
                    do_arb  = 1'b1;
                end else if (burst_q == BURST_MAX && ks_req_i) begin
                    gnt_ks  = 1'b1;
                    last_d  = OWN_KS;
                    state_d = S_IDLE;
                    burst_d = '0;
                end else begin
                    gnt_ss = 1'b1;
                    last_d = OWN_SS;
                    if (burst_q != BURST_MAX) burst_d = burst_q + BURST_ONE;
                    if (!ss_lock_i) begin
                        state_d = S_IDLE;
                        burst_d = '0;
                    end
                end
            end
            S_OWN_KS: begin
                if (!ks_req_i) begin
                    state_d = S_IDLE;
                    burst_d = '0;
                    do_arb  = 1'b1;
                end else if (burst_q == BURST_MAX && ss_req_i) begin
                    gnt_ss  = 1'b1;
                    last_d  = OWN_SS;
                    state_d = S_IDLE;
                    burst_d = '0;
                end else begin
                    gnt_ks = 1'b1;
                    last_d = OWN_KS;
                    if (burst_q != BURST_MAX) burst_d = burst_q + BURST_ONE;
                    if (!ks_lock_i) begin
                        state_d = S_IDLE;
                        burst_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                burst_d = '0;
            end
        endcase

        if (do_arb) begin
            // SS wins only if alone or if KS had the previous grant.
            if (ss_req_i && (!ks_req_i || last_q == OWN_KS)) begin
                gnt_ss = 1'b1;
                last_d = OWN_SS;
                if (ss_lock_i) begin
                    state_d = S_OWN_SS;
                    burst_d = BURST_ONE;
                end
            end else if (ks_req_i) begin
                gnt_ks = 1'b1;
                last_d = OWN_KS;
                if (ks_lock_i) begin
                    state_d = S_OWN_KS;
                    burst_d = BURST_ONE;
                end
            end
        end
    end

    // Grants are combinational; keep them quiet while reset is asserted.
    assign ss_gnt_o  = gnt_ss & rst_ni;
    assign ks_gnt_o  = gnt_ks & rst_ni;
    assign grant_any = ss_gnt_o | ks_gnt_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            burst_q    <= '0;
            last_q     <= OWN_SS;
            rom_ce_q   <= 1'b0;
            rom_re_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            burst_q  <= burst_d;
            last_q   <= last_d;
            rom_ce_q <= grant_any;
            rom_re_q <= grant_any;
            if (grant_any) begin
                rom_addr_q <= ks_gnt_o ? ks_addr_i : ss_addr_i;
            end
        end
    end

    sbox_arb_tagpipe #(
        .DEPTH(ROM_LAT + 1)
    ) u_tagpipe (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (grant_any),
        .owner_i    (ks_gnt_o ? OWN_KS : OWN_SS),
        .tag_o      (tag_out),
        .any_valid_o(tag_busy)
    );

    assign rom_ce_o    = rom_ce_q;
    assign rom_re_o    = rom_re_q;
    assign rom_addr_o  = rom_addr_q;

    assign ss_rvalid_o = tag_out.valid && (tag_out.owner == OWN_SS);
    assign ks_rvalid_o = tag_out.valid && (tag_out.owner == OWN_KS);
    assign ss_rdata_o  = ss_rvalid_o ? rom_data_i : 8'h00;
    assign ks_rdata_o  = ks_rvalid_o ? rom_data_i : 8'h00;

    assign busy_o      = tag_busy | rom_ce_q;

endmodule

// File: tb/tb_sbox_arbiter.sv
module tb_sbox_arbiter;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       ss_req = 1'b0, ss_lock = 1'b0, ks_req = 1'b0, ks_lock = 1'b0;
    logic [7:0] ss_addr = 8'h00, ks_addr = 8'h00;
    logic       ss_gnt, ss_rvalid, ks_gnt, ks_rvalid;
    logic [7:0] ss_rdata, ks_rdata;
    logic       rom_ce, rom_re, busy;
    logic [7:0] rom_addr;
    logic [7:0] rom_data = 8'h00;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sbox_arbiter dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .ss_req_i   (ss_req),
        .ss_addr_i  (ss_addr),
        .ss_lock_i  (ss_lock),
        .ss_gnt_o   (ss_gnt),
        .ss_rvalid_o(ss_rvalid),
        .ss_rdata_o (ss_rdata),
        .ks_req_i   (ks_req),
        .ks_addr_i  (ks_addr),
        .ks_lock_i  (ks_lock),
        .ks_gnt_o   (ks_gnt),
        .ks_rvalid_o(ks_rvalid),
        .ks_rdata_o (ks_rdata),
        .rom_ce_o   (rom_ce),
        .rom_re_o   (rom_re),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .busy_o     (busy)
    );

    // ROM model, one-cycle synchronous read; only the AES entries the bench uses.
    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        case (a)
            8'h00:   return 8'h63;
            8'h01:   return 8'h7c;
            8'h53:   return 8'hed;
            8'hff:   return 8'h16;
            default: return a ^ 8'h5a;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rom_ce && rom_re) rom_data <= sbox_ref(rom_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        ss_req = 0; ks_req = 0; ss_lock = 0; ks_lock = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        ss_req = 1; ks_req = 1; ss_addr = 8'h53; ks_addr = 8'h01;
        repeat (2) @(posedge clk);
        #4;
        checks++;
        if ({ss_gnt, ks_gnt, ss_rvalid, ks_rvalid, rom_ce, rom_re, busy} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got gnt=%b%b rv=%b%b ce=%b re=%b busy=%b exp all 0",
                     ss_gnt, ks_gnt, ss_rvalid, ks_rvalid, rom_ce, rom_re, busy);
        end
        checks++;
        if ({rom_addr, ss_rdata, ks_rdata} !== 24'h0) begin
            failures++;
            $display("FAIL reset_data got addr=%h ssd=%h ksd=%h exp 0", rom_addr, ss_rdata, ks_rdata);
        end
    endtask

    task automatic test_single();
        do_reset();
        ss_req = 1; ss_addr = 8'h00; ks_req = 0;
        #3;
        checks++;
        if ({ss_gnt, ks_gnt} !== 2'b10) begin
            failures++; $display("FAIL single_gnt got ss/ks=%b%b exp=10", ss_gnt, ks_gnt);
        end
        step(); ss_req = 0; #3;
        checks++;
        if ({rom_ce, rom_re, rom_addr, busy, ss_rvalid} !== {2'b11, 8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL single_rom got ce=%b re=%b addr=%h busy=%b rv=%b exp ce=1 re=1 addr=00 busy=1 rv=0",
                     rom_ce, rom_re, rom_addr, busy, ss_rvalid);
        end
        step(); #3;
        checks++;
        if ({ss_rvalid, ss_rdata, ks_rvalid} !== {1'b1, 8'h63, 1'b0}) begin
            failures++;
            $display("FAIL single_ret got ssrv=%b ssd=%h ksrv=%b exp 1 63 0", ss_rvalid, ss_rdata, ks_rvalid);
        end
        step(); #3;
        checks++;
        if ({busy, ss_rvalid, ks_rvalid, rom_ce} !== 4'b0) begin
            failures++;
            $display("FAIL single_idle got busy=%b ssrv=%b ksrv=%b ce=%b exp 0", busy, ss_rvalid, ks_rvalid, rom_ce);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        ss_req = 1; ss_addr = 8'h53; ks_req = 1; ks_addr = 8'h01;
        #3;
        checks++;
        if ({ks_gnt, ss_gnt} !== 2'b10) begin
            failures++; $display("FAIL conflict_c0 got ks/ss=%b%b exp=10", ks_gnt, ss_gnt);
        end
        step(); #3;
        checks++;
        if ({ks_gnt, ss_gnt, rom_addr} !== {2'b01, 8'h01}) begin
            failures++; $display("FAIL conflict_c1 got ks/ss=%b%b addr=%h exp=01 addr=01", ks_gnt, ss_gnt, rom_addr);
        end
        step(); ss_req = 0; ks_req = 0; ss_addr = 8'h00; #3;
        checks++;
        if ({ks_rvalid, ks_rdata, ss_rvalid, rom_addr} !== {1'b1, 8'h7c, 1'b0, 8'h53}) begin
            failures++;
            $display("FAIL conflict_c2 got ksrv=%b ksd=%h ssrv=%b addr=%h exp 1 7c 0 53",
                     ks_rvalid, ks_rdata, ss_rvalid, rom_addr);
        end
        step(); #3;
        checks++;
        if ({ss_rvalid, ss_rdata, ks_rvalid, rom_ce, rom_addr} !== {1'b1, 8'hed, 1'b0, 1'b0, 8'h53}) begin
            failures++;
            $display("FAIL conflict_c3 got ssrv=%b ssd=%h ksrv=%b ce=%b addr=%h exp 1 ed 0 0 53",
                     ss_rvalid, ss_rdata, ks_rvalid, rom_ce, rom_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic gk, gs, vk, vs;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            ss_req = (c < 8); ks_req = (c < 8); ss_addr = 8'h53; ks_addr = 8'hff;
            #3;
            gk = (c < 8) && (c % 2 == 0);
            gs = (c < 8) && (c % 2 == 1);
            vk = (c >= 2) && ((c - 2) % 2 == 0);
            vs = (c >= 2) && ((c - 2) % 2 == 1);
            checks++;
            if ({ks_gnt, ss_gnt} !== {gk, gs}) begin
                failures++; $display("FAIL b2b_gnt cyc=%0d got ks/ss=%b%b exp=%b%b", c, ks_gnt, ss_gnt, gk, gs);
            end
            checks++;
            if ({ks_rvalid, ss_rvalid} !== {vk, vs}) begin
                failures++; $display("FAIL b2b_rv cyc=%0d got ks/ss=%b%b exp=%b%b", c, ks_rvalid, ss_rvalid, vk, vs);
            end
            if (vk) begin
                checks++;
                if (ks_rdata !== 8'h16) begin
                    failures++; $display("FAIL b2b_ksd cyc=%0d got=%h exp=16", c, ks_rdata);
                end
            end
            if (vs) begin
                checks++;
                if (ss_rdata !== 8'hed) begin
                    failures++; $display("FAIL b2b_ssd cyc=%0d got=%h exp=ed", c, ss_rdata);
                end
            end
        end
    endtask

    task automatic test_lock();
        logic [7:0] kr = 8'b0000_1111, kl = 8'b0000_0111, sr = 8'b0001_1111;
        logic [7:0] gk = 8'b0000_1111, gs = 8'b0001_0000;
        logic [7:0] vk = 8'b0011_1100, vs = 8'b0100_0000;
        logic [7:0] ka [8];
        logic [7:0] ed [8];
        ka = '{8'h00, 8'h01, 8'h53, 8'hff, 8'h00, 8'h00, 8'h00, 8'h00};
        ed = '{8'h00, 8'h00, 8'h63, 8'h7c, 8'hed, 8'h16, 8'h63, 8'h00};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            ks_req = kr[c]; ks_lock = kl[c]; ks_addr = ka[c];
            ss_req = sr[c]; ss_lock = 0; ss_addr = 8'h00;
            #3;
            checks++;
            if ({ks_gnt, ss_gnt} !== {gk[c], gs[c]}) begin
                failures++; $display("FAIL lock_gnt cyc=%0d got ks/ss=%b%b exp=%b%b", c, ks_gnt, ss_gnt, gk[c], gs[c]);
            end
            checks++;
            if ({ks_rvalid, ss_rvalid} !== {vk[c], vs[c]}) begin
                failures++; $display("FAIL lock_rv cyc=%0d got ks/ss=%b%b exp=%b%b", c, ks_rvalid, ss_rvalid, vk[c], vs[c]);
            end
            if (vk[c]) begin
                checks++;
                if (ks_rdata !== ed[c]) begin
                    failures++; $display("FAIL lock_ksd cyc=%0d got=%h exp=%h", c, ks_rdata, ed[c]);
                end
            end
            if (vs[c]) begin
                checks++;
                if (ss_rdata !== ed[c]) begin
                    failures++; $display("FAIL lock_ssd cyc=%0d got=%h exp=%h", c, ss_rdata, ed[c]);
                end
            end
        end
        ks_req = 0; ks_lock = 0;
    endtask

    task automatic test_burst_handover();
        logic [9:0] kr = 10'b00_0111_1111, kl = 10'b00_0011_1111, sr = 10'b00_0001_1111;
        logic [9:0] gk = 10'b00_0110_1111, gs = 10'b00_0001_0000;
        logic [9:0] vk = 10'b01_1011_1100, vs = 10'b00_0100_0000;
        logic [7:0] ka [10];
        logic [7:0] ed [10];
        ka = '{8'h00, 8'h01, 8'h53, 8'hff, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        ed = '{8'h00, 8'h00, 8'h63, 8'h7c, 8'hed, 8'h16, 8'h16, 8'h63, 8'h7c, 8'h00};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            ks_req = kr[c]; ks_lock = kl[c]; ks_addr = ka[c];
            ss_req = sr[c]; ss_lock = 0; ss_addr = 8'hff;
            #3;
            checks++;
            if ({ks_gnt, ss_gnt} !== {gk[c], gs[c]}) begin
                failures++; $display("FAIL burst_gnt cyc=%0d got ks/ss=%b%b exp=%b%b", c, ks_gnt, ss_gnt, gk[c], gs[c]);
            end
            checks++;
            if ({ks_rvalid, ss_rvalid} !== {vk[c], vs[c]}) begin
                failures++; $display("FAIL burst_rv cyc=%0d got ks/ss=%b%b exp=%b%b", c, ks_rvalid, ss_rvalid, vk[c], vs[c]);
            end
            if (vk[c]) begin
                checks++;
                if (ks_rdata !== ed[c]) begin
                    failures++; $display("FAIL burst_ksd cyc=%0d got=%h exp=%h", c, ks_rdata, ed[c]);
                end
            end
            if (vs[c]) begin
                checks++;
                if (ss_rdata !== ed[c]) begin
                    failures++; $display("FAIL burst_ssd cyc=%0d got=%h exp=%h", c, ss_rdata, ed[c]);
                end
            end
        end
        ks_req = 0; ks_lock = 0;
    endtask

    // KS locks alone past MAX_BURST (counter must saturate), then SS arrives.
    task automatic test_saturate();
        logic [9:0] kr = 10'b00_1111_1111, sr = 10'b00_0100_0000;
        logic [9:0] gk = 10'b00_1011_1111, gs = 10'b00_0100_0000;
        logic [9:0] vk = 10'b10_1111_1100, vs = 10'b01_0000_0000;
        logic [7:0] ed [10];
        ed = '{8'h00, 8'h00, 8'h63, 8'h63, 8'h63, 8'h63, 8'h63, 8'h63, 8'h7c, 8'h63};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            ks_req = kr[c]; ks_lock = kr[c]; ks_addr = 8'h00;
            ss_req = sr[c]; ss_lock = 0; ss_addr = 8'h01;
            #3;
            checks++;
            if ({ks_gnt, ss_gnt} !== {gk[c], gs[c]}) begin
                failures++; $display("FAIL sat_gnt cyc=%0d got ks/ss=%b%b exp=%b%b", c, ks_gnt, ss_gnt, gk[c], gs[c]);
            end
            checks++;
            if ({ks_rvalid, ss_rvalid} !== {vk[c], vs[c]}) begin
                failures++; $display("FAIL sat_rv cyc=%0d got ks/ss=%b%b exp=%b%b", c, ks_rvalid, ss_rvalid, vk[c], vs[c]);
            end
            if (vk[c]) begin
                checks++;
                if (ks_rdata !== ed[c]) begin
                    failures++; $display("FAIL sat_ksd cyc=%0d got=%h exp=%h", c, ks_rdata, ed[c]);
                end
            end
            if (vs[c]) begin
                checks++;
                if (ss_rdata !== ed[c]) begin
                    failures++; $display("FAIL sat_ssd cyc=%0d got=%h exp=%h", c, ss_rdata, ed[c]);
                end
            end
        end
        ks_req = 0; ks_lock = 0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        ss_req = 1; ss_addr = 8'h00; ks_req = 0;
        #3;
        checks++;
        if (ss_gnt !== 1'b1) begin
            failures++; $display("FAIL midrst_gnt0 got=%b exp=1", ss_gnt);
        end
        for (int c = 1; c < 3; c++) begin
            step(); rst_ni = 1'b0; ss_req = 1; ss_addr = 8'h01; ks_req = 1; #3;
            checks++;
            if ({ss_gnt, ks_gnt, ss_rvalid, ks_rvalid, rom_ce, rom_re, busy, rom_addr, ss_rdata} !== 23'h0) begin
                failures++;
                $display("FAIL midrst_hold cyc=%0d got gnt=%b%b rv=%b%b ce=%b re=%b busy=%b addr=%h ssd=%h exp all 0",
                         c, ss_gnt, ks_gnt, ss_rvalid, ks_rvalid, rom_ce, rom_re, busy, rom_addr, ss_rdata);
            end
        end
        step(); rst_ni = 1'b1; ss_req = 1; ss_addr = 8'h01; ks_req = 0; #3;
        checks++;
        if ({ss_gnt, ss_rvalid} !== 2'b10) begin
            failures++; $display("FAIL midrst_regnt got gnt=%b rv=%b exp gnt=1 rv=0", ss_gnt, ss_rvalid);
        end
        step(); ss_req = 0; #3;
        checks++;
        if ({ss_rvalid, rom_ce, rom_addr} !== {1'b0, 1'b1, 8'h01}) begin
            failures++; $display("FAIL midrst_c4 got rv=%b ce=%b addr=%h exp 0 1 01", ss_rvalid, rom_ce, rom_addr);
        end
        step(); #3;
        checks++;
        if ({ss_rvalid, ss_rdata} !== {1'b1, 8'h7c}) begin
            failures++; $display("FAIL midrst_ret got rv=%b d=%h exp 1 7c", ss_rvalid, ss_rdata);
        end
        step(); #3;
        checks++;
        if ({ss_rvalid, busy} !== 2'b00) begin
            failures++; $display("FAIL midrst_end got rv=%b busy=%b exp 0 0", ss_rvalid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_back_to_back();
        test_lock();
        test_burst_handover();
        test_saturate();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
